if_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined RISC-V core, upstream of decode. It holds the program counter, reads a word-addressed instruction memory, and drives the IF/ID pipeline register. It honours stalls from the hazard unit and redirects from the EX-stage branch/jump resolution. It also has a program-load write port that benches use to preload code before releasing reset_pc.

---
 rtl/if_fetch_stage.sv | 98 +++++++++
 tb/tb_if_fetch_stage.sv | 136 +++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: PC, word-addressed imem, IF/ID register
// Redirect beats stall; flush turns the next IF/ID load into a bubble.
module if_fetch_stage #(
  parameter int               XLEN       = 32,
  parameter int               IMEM_DEPTH = 256,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter logic [31:0]      NOP_INSTR  = 32'h0000_0013
) (
  input  logic            clock,
  input  logic            reset_pc,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            imem_we,
  input  logic [XLEN-1:0] imem_waddr,
  input  logic [31:0]     imem_wdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);

  localparam int AW = $clog2(IMEM_DEPTH);

  // Contents survive reset; power-up image is all bubbles.
  logic [31:0] imem_q [0:IMEM_DEPTH-1] = '{default: NOP_INSTR};

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
  logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic            ifid_valid_q, ifid_valid_d;

  logic [XLEN-1:0] pc_plus4;
  logic [AW-1:0]   rd_idx, wr_idx;
  logic [31:0]     fetch_word;
  logic            unused_addr_bits;

  assign rd_idx     = pc_q[AW+1:2];
  assign wr_idx     = imem_waddr[AW+1:2];
  assign fetch_word = imem_q[rd_idx];
  assign pc_plus4   = pc_q + XLEN'(4);
  assign unused_addr_bits = ^{redirect_target[1:0], imem_waddr};

  always_ff @(posedge clock) begin
    if (imem_we) imem_q[wr_idx] <= imem_wdata;
  end

  always_comb begin
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    if (redirect_valid || flush) begin
      ifid_pc_d    = '0;
      ifid_pc4_d   = '0;
      ifid_instr_d = NOP_INSTR;
      ifid_valid_d = 1'b0;
    end
    if (redirect_valid) begin
      pc_d = {redirect_target[XLEN-1:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
      if (!flush) begin
        ifid_pc_d    = pc_q;
        ifid_pc4_d   = pc_plus4;
        ifid_instr_d = fetch_word;
        ifid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset_pc) begin
      pc_q         <= RESET_PC;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign pc_out         = pc_q;
  assign if_id_pc       = ifid_pc_q;
  assign if_id_pc_plus4 = ifid_pc4_q;
  assign if_id_instr    = ifid_instr_q;
  assign if_id_valid    = ifid_valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed and randomized checks of if_fetch_stage against a reference model
module tb_if_fetch_stage;

  logic        clock = 1'b0;
  logic        reset_pc = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        imem_we = 1'b0;
  logic [31:0] imem_waddr = '0, imem_wdata = '0;
  logic [31:0] pc_out, if_id_pc, if_id_pc_plus4, if_id_instr;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr;
  logic        m_valid;

  if_fetch_stage dut (
    .clock(clock), .reset_pc(reset_pc), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc_out(pc_out), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bubble();
    m_ipc = 0; m_ipc4 = 0; m_instr = 32'h13; m_valid = 0;
  endtask

  task automatic step(input logic r, input logic st, input logic fl, input logic rv,
                      input logic [31:0] rt, input logic we, input logic [31:0] wa,
                      input logic [31:0] wd, input string tag);
    reset_pc = r; stall = st; flush = fl; redirect_valid = rv; redirect_target = rt;
    imem_we = we; imem_waddr = wa; imem_wdata = wd;
    @(posedge clock);
    if (r) begin
      m_pc = 0; bubble();
    end else if (rv) begin
      m_pc = rt & 32'hFFFF_FFFC; bubble();
    end else if (st) begin
      if (fl) bubble();
    end else begin
      if (fl) bubble();
      else begin
        m_ipc = m_pc; m_ipc4 = m_pc + 4; m_instr = m_mem[(m_pc >> 2) % 256]; m_valid = 1;
      end
      m_pc = m_pc + 4;
    end
    if (we) m_mem[(wa >> 2) % 256] = wd;
    #1;
    chk({tag, ".pc_out"}, pc_out, m_pc);
    chk({tag, ".if_id_pc"}, if_id_pc, m_ipc);
    chk({tag, ".if_id_pc_plus4"}, if_id_pc_plus4, m_ipc4);
    chk({tag, ".if_id_instr"}, if_id_instr, m_instr);
    chk({tag, ".if_id_valid"}, {31'b0, if_id_valid}, {31'b0, m_valid});
  endtask

  task automatic run(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  logic [31:0] saved_pc;

  initial begin
    for (int i = 0; i < 256; i++) m_mem[i] = 32'h13;
    m_pc = 0; bubble();

    // program load during reset, then hold reset for 10 cycles total
    step(1, 0, 0, 0, 0, 1, 32'h0, 32'h0050_0093, "load0");
    step(1, 0, 0, 0, 0, 1, 32'h4, 32'h00A0_0113, "load1");
    step(1, 0, 0, 0, 0, 1, 32'h8, 32'h0020_81B3, "load2");
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0, 0, 0, "reset");

    run("fetch0");
    run("fetch4");
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0, 0, "stall");
    run("resume8");

    // redirect dominates stall
    step(0, 1, 0, 1, 32'h40, 0, 0, 0, "redir_stall");
    run("after_redir");

    step(0, 0, 0, 1, 32'h47, 0, 0, 0, "misalign");
    step(0, 0, 0, 1, 32'h3FC, 0, 0, 0, "jmp3fc");
    run("fetch3fc");
    run("alias400");

    // stall+flush holds pc, flush alone advances
    step(0, 1, 1, 0, 0, 0, 0, 0, "stall_flush");
    step(0, 0, 1, 0, 0, 0, 0, 0, "flush");
    run("post_flush");

    // write-during-fetch returns old word; refetch sees new
    step(0, 0, 0, 1, 32'h80, 0, 0, 0, "to80");
    step(0, 0, 0, 0, 0, 1, 32'h80, 32'hDEAD_BEEF, "wr_same");
    step(0, 0, 0, 1, 32'h80, 0, 0, 0, "back80");
    run("refetch80");

    // pc wrap at top of address space
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, "to_top");
    run("wrap");

    // reset mid-stream at pc 0x20, memory retained
    step(0, 0, 0, 1, 32'h10, 0, 0, 0, "to10");
    while (m_pc != 32'h20) run("run_to20");
    step(1, 0, 0, 0, 0, 0, 0, 0, "mid_reset");
    run("retained0");
    run("retained4");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt, wa;
      rt = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 1023);
      saved_pc = m_pc;
      wa = ($urandom_range(0, 3) == 0) ? saved_pc : $urandom_range(0, 2047);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, rt, $urandom_range(0, 3) == 0, wa, $urandom, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
